// File: rtl/param_seq_accumulator_pkg.sv
// Shared mode codes and FSM state encoding for the sequence accumulator.
package param_seq_acc_pkg;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_SUB   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/param_seq_accumulator_alu.sv
// Combinational add/sub/load/clear unit; carries the sticky overflow forward.
module acc_alu
  import param_seq_acc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] acc_cur,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic             ovf_cur,
  output logic [WIDTH-1:0] acc_next,
  output logic             ovf_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Bit WIDTH of sum is the carry; bit WIDTH of diff is the borrow.
  assign sum  = {1'b0, acc_cur} + {1'b0, data};
  assign diff = {1'b0, acc_cur} - {1'b0, data};

  always_comb begin
    acc_next = acc_cur;
    ovf_next = ovf_cur;
    case (mode)
      MODE_ADD: begin
        ovf_next = ovf_cur | sum[WIDTH];
        if ((SATURATE != 0) && sum[WIDTH]) acc_next = '1;
        else                               acc_next = sum[WIDTH-1:0];
      end
      MODE_SUB: begin
        ovf_next = ovf_cur | diff[WIDTH];
        if ((SATURATE != 0) && diff[WIDTH]) acc_next = '0;
        else                                acc_next = diff[WIDTH-1:0];
      end
      MODE_LOAD: begin
        acc_next = data;
        ovf_next = 1'b0;
      end
      default: begin
        acc_next = '0;
        ovf_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_seq_accumulator.sv
// Running accumulator with valid/ready handshakes, op counter and fixed-length frames.
//   state    | meaning
//   ST_RUN   | accepting ops whenever the output slot is free or being consumed
//   ST_DRAIN | frame-closing result pending; no accepts until it is consumed
module param_seq_accumulator
  import param_seq_acc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int FRAME_LEN = 0,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     acc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf,
  output logic                 last
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_d;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 ovf_d;
  logic                 last_d;
  logic                 valid_d;

  logic [WIDTH-1:0]     alu_acc;
  logic                 alu_ovf;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 accept;
  logic                 consume;
  logic                 is_clear;
  logic                 frame_end;

  // Reset gating keeps in_ready low during a reset cycle even though state is already RUN.
  assign in_ready  = reset && (state_q == ST_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign is_clear  = (mode == MODE_CLEAR);
  assign count_inc = count + CNT_WIDTH'(1);
  assign frame_end = (FRAME_LEN != 0) && !is_clear && (count_inc == CNT_WIDTH'(FRAME_LEN));

  acc_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .acc_cur  (acc),
    .data     (in_data),
    .mode     (mode),
    .ovf_cur  (ovf),
    .acc_next (alu_acc),
    .ovf_next (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    count_d = count;
    ovf_d   = ovf;
    last_d  = last;
    valid_d = out_valid;
    if (accept) begin
      acc_d   = alu_acc;
      ovf_d   = alu_ovf;
      count_d = is_clear ? '0 : count_inc;
      last_d  = frame_end;
      valid_d = 1'b1;
      if (frame_end) state_d = ST_DRAIN;
    end else if (consume) begin
      valid_d = 1'b0;
      if (state_q == ST_DRAIN) begin
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        last_d  = 1'b0;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      last      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc       <= acc_d;
      count     <= count_d;
      ovf       <= ovf_d;
      last      <= last_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_param_seq_accumulator.sv
// Drives three accumulator configurations from one stimulus stream against per-instance reference models.
module tb_param_seq_accumulator;
  import param_seq_acc_pkg::*;

  localparam int W   = 8;
  localparam int N   = 3;
  localparam int MAX = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] mode = MODE_ADD;

  logic       in_ready_o  [N];
  logic       out_valid_o [N];
  logic [7:0] acc_o       [N];
  logic [7:0] count_o     [N];
  logic       ovf_o       [N];
  logic       last_o      [N];

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // u0: wrap, free-running; u1: saturating with 3-bit counter; u2: wrap, 4-op frames
  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int FL  = (g == 2) ? 4 : 0;
    localparam int SAT = (g == 1) ? 1 : 0;
    localparam int CW  = (g == 1) ? 3 : 8;

    logic [CW-1:0] cnt;

    param_seq_accumulator #(
      .WIDTH     (W),
      .CNT_WIDTH (CW),
      .FRAME_LEN (FL),
      .SATURATE  (SAT)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_o[g]),
      .in_data   (in_data),
      .mode      (mode),
      .out_valid (out_valid_o[g]),
      .out_ready (out_ready),
      .acc       (acc_o[g]),
      .count     (cnt),
      .ovf       (ovf_o[g]),
      .last      (last_o[g])
    );

    assign count_o[g] = 8'(cnt);

    int m_acc = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_last = 1'b0;
    bit m_valid = 1'b0;
    bit m_drain = 1'b0;

    always @(posedge clk) begin
      int  s;
      int  nacc;
      int  ncnt;
      bit  nov;
      bit  rdy;
      if (!reset) begin
        m_acc <= 0; m_cnt <= 0; m_ovf <= 1'b0;
        m_last <= 1'b0; m_valid <= 1'b0; m_drain <= 1'b0;
      end else begin
        rdy = !m_drain && (!m_valid || out_ready);
        if (rdy && in_valid) begin
          nov  = m_ovf;
          nacc = m_acc;
          ncnt = (m_cnt + 1) % (1 << CW);
          case (mode)
            MODE_ADD: begin
              s = m_acc + int'(in_data);
              if (s > MAX) begin
                nov  = 1'b1;
                nacc = (SAT != 0) ? MAX : s - (MAX + 1);
              end else nacc = s;
            end
            MODE_SUB: begin
              s = m_acc - int'(in_data);
              if (s < 0) begin
                nov  = 1'b1;
                nacc = (SAT != 0) ? 0 : s + (MAX + 1);
              end else nacc = s;
            end
            MODE_LOAD: begin
              nacc = int'(in_data);
              nov  = 1'b0;
            end
            default: begin
              nacc = 0;
              nov  = 1'b0;
              ncnt = 0;
            end
          endcase
          m_acc   <= nacc;
          m_ovf   <= nov;
          m_cnt   <= ncnt;
          m_valid <= 1'b1;
          if (mode != MODE_CLEAR && FL != 0 && ncnt == FL) begin
            m_last  <= 1'b1;
            m_drain <= 1'b1;
          end else begin
            m_last <= 1'b0;
          end
        end else if (m_valid && out_ready) begin
          m_valid <= 1'b0;
          if (m_drain) begin
            m_acc <= 0; m_cnt <= 0; m_ovf <= 1'b0;
            m_last <= 1'b0; m_drain <= 1'b0;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (model_on) begin
        check($sformatf("u%0d in_ready", g), 32'(in_ready_o[g]),
              32'(reset && !m_drain && (!m_valid || out_ready)));
        check($sformatf("u%0d out_valid", g), 32'(out_valid_o[g]), 32'(m_valid));
        check($sformatf("u%0d acc", g), 32'(acc_o[g]), 32'(m_acc));
        check($sformatf("u%0d count", g), 32'(count_o[g]), 32'(m_cnt));
        check($sformatf("u%0d ovf", g), 32'(ovf_o[g]), 32'(m_ovf));
        check($sformatf("u%0d last", g), 32'(last_o[g]), 32'(m_last));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d, input logic r);
    in_valid  = v;
    mode      = m;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, MODE_ADD, 8'd0, 1'b1);
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with an ADD 5 offered: nothing may be accepted
    reset = 1'b0;
    drive(1'b1, MODE_ADD, 8'd5, 1'b1);
    cyc();
    model_on = 1'b1;
    cyc();
    check("rst acc", 32'(acc_o[0]), 32'd0);
    check("rst out_valid", 32'(out_valid_o[0]), 32'd0);
    check("rst in_ready", 32'(in_ready_o[0]), 32'd0);
    check("rst count", 32'(count_o[0]), 32'd0);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("release in_ready", 32'(in_ready_o[0]), 32'd1);
    check("release in_ready u2", 32'(in_ready_o[2]), 32'd1);

    // Wrapping add with sticky overflow
    drive(1'b1, MODE_ADD, 8'd100, 1'b1);
    cyc(); check("add1 acc", 32'(acc_o[0]), 32'd100); check("add1 ovf", 32'(ovf_o[0]), 32'd0);
    cyc(); check("add2 acc", 32'(acc_o[0]), 32'd200); check("add2 ovf", 32'(ovf_o[0]), 32'd0);
    cyc(); check("add3 acc", 32'(acc_o[0]), 32'd44);  check("add3 ovf", 32'(ovf_o[0]), 32'd1);
    in_data = 8'd1;
    cyc(); check("add4 acc", 32'(acc_o[0]), 32'd45);  check("add4 ovf", 32'(ovf_o[0]), 32'd1);
    check("add4 count", 32'(count_o[0]), 32'd4);
    check("sat add3 acc", 32'(acc_o[1]), 32'd255);

    // Saturation, then clear and underflow
    do_reset();
    drive(1'b1, MODE_LOAD, 8'd250, 1'b1);
    cyc();
    drive(1'b1, MODE_ADD, 8'd10, 1'b1);
    cyc();
    check("sat hi acc", 32'(acc_o[1]), 32'd255);
    check("sat hi ovf", 32'(ovf_o[1]), 32'd1);
    check("wrap hi acc", 32'(acc_o[0]), 32'd4);
    drive(1'b1, MODE_CLEAR, 8'd77, 1'b1);
    cyc();
    check("clr acc", 32'(acc_o[1]), 32'd0);
    check("clr ovf", 32'(ovf_o[1]), 32'd0);
    check("clr last", 32'(last_o[1]), 32'd0);
    drive(1'b1, MODE_SUB, 8'd1, 1'b1);
    cyc();
    check("sat lo acc", 32'(acc_o[1]), 32'd0);
    check("sat lo ovf", 32'(ovf_o[1]), 32'd1);
    check("sat lo count", 32'(count_o[1]), 32'd1);
    check("wrap lo acc", 32'(acc_o[0]), 32'd255);

    // Backpressure
    do_reset();
    drive(1'b1, MODE_ADD, 8'd3, 1'b1);
    cyc();
    check("bp first acc", 32'(acc_o[0]), 32'd3);
    drive(1'b1, MODE_ADD, 8'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp in_ready", 32'(in_ready_o[0]), 32'd0);
      cyc();
      check("bp hold acc", 32'(acc_o[0]), 32'd3);
      check("bp hold valid", 32'(out_valid_o[0]), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready_o[0]), 32'd1);
    cyc();
    check("bp next acc", 32'(acc_o[0]), 32'd7);
    in_valid = 1'b0;
    cyc();

    // Frame of four, held in DRAIN, then consumed
    do_reset();
    drive(1'b1, MODE_ADD, 8'd1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("frm acc", 32'(acc_o[2]), 32'(i));
      check("frm last", 32'(last_o[2]), 32'd0);
    end
    cyc();
    check("frm end acc", 32'(acc_o[2]), 32'd4);
    check("frm end count", 32'(count_o[2]), 32'd4);
    check("frm end last", 32'(last_o[2]), 32'd1);
    drive(1'b1, MODE_ADD, 8'd2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("drain in_ready", 32'(in_ready_o[2]), 32'd0);
      cyc();
      check("drain hold last", 32'(last_o[2]), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("drain consume in_ready", 32'(in_ready_o[2]), 32'd0);
    cyc();
    check("post drain valid", 32'(out_valid_o[2]), 32'd0);
    check("post drain acc", 32'(acc_o[2]), 32'd0);
    check("post drain count", 32'(count_o[2]), 32'd0);
    cyc();
    check("new frame acc", 32'(acc_o[2]), 32'd2);
    check("new frame count", 32'(count_o[2]), 32'd1);

    // Reset while a last result is pending
    do_reset();
    drive(1'b1, MODE_ADD, 8'd1, 1'b1);
    repeat (4) cyc();
    drive(1'b0, MODE_ADD, 8'd0, 1'b0);
    cyc();
    check("pre rst last", 32'(last_o[2]), 32'd1);
    reset = 1'b0;
    cyc();
    check("drain rst acc", 32'(acc_o[2]), 32'd0);
    check("drain rst count", 32'(count_o[2]), 32'd0);
    check("drain rst last", 32'(last_o[2]), 32'd0);
    check("drain rst valid", 32'(out_valid_o[2]), 32'd0);
    reset = 1'b1;
    #1;
    check("drain rst in_ready", 32'(in_ready_o[2]), 32'd1);
    cyc();
    check("drain rst lost", 32'(out_valid_o[2]), 32'd0);

    // Randomized traffic, checked every cycle by the models
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       in_data = 8'd0;
        1:       in_data = 8'd255;
        default: in_data = 8'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
